// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants, response record and parity helper for the
//               instruction memory fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int c_data_w       = 16;
    localparam int c_addr_w       = 6;
    localparam int c_depth        = 16;
    localparam int c_resp_depth   = 3;
    localparam int c_parity_max_w = 64;
    localparam logic [c_data_w-1:0] c_nop_word = 16'h0000;

    typedef struct packed {
        logic [c_data_w-1:0] data;
        logic [c_addr_w-1:0] addr;
        logic                err;
    } imem_resp_t;

    // Zero-extension does not change parity, so any word up to 64 bits fits.
    function automatic logic even_parity(input logic [c_parity_max_w-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : imem_resp_fifo
// Description : DEPTH-entry FIFO of response records with occupancy output and
//               synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_resp_fifo
    import imem_pkg::*;
#(
    parameter type T     = imem_resp_t,
    parameter int  DEPTH = c_resp_depth,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  T                 din,
    input  logic             pop,
    output T                 dout,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_full = CNT_W'(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic               w_push;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_full) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_mem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_fetch
// Description : Loadable instruction memory with registered, handshaked fetch
//               port, response queue, flush and out-of-range error reporting.
//               Define INSTR_PARITY_EN to store and check an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_fetch
    import imem_pkg::*;
#(
    parameter int                DATA_W     = c_data_w,
    parameter int                ADDR_W     = c_addr_w,
    parameter int                DEPTH      = c_depth,
    parameter int                RESP_DEPTH = c_resp_depth,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(c_nop_word)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err
);

`ifdef INSTR_PARITY_EN
    localparam int c_mem_w = DATA_W + 1;
`else
    localparam int c_mem_w = DATA_W;
`endif
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_lim_w = ADDR_W + 1;
    localparam int c_cnt_w = $clog2(RESP_DEPTH + 1);
    localparam int c_occ_w = c_cnt_w + 1;
    localparam logic [c_lim_w-1:0] c_depth_lim = c_lim_w'(DEPTH);
    localparam logic [c_occ_w-1:0] c_credit    = c_occ_w'(RESP_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } resp_t;

    logic [c_mem_w-1:0] r_mem [DEPTH];
    logic               r_s1_valid;
    resp_t              r_s1;

    logic               w_ld_in_range;
    logic               w_rd_in_range;
    logic [c_idx_w-1:0] w_ld_idx;
    logic [c_idx_w-1:0] w_rd_idx;
    logic [c_mem_w-1:0] w_ld_word;
    logic [c_mem_w-1:0] w_rd_word;
    logic               w_rd_err;
    logic               w_accept;
    logic [c_cnt_w-1:0] w_count;
    logic [c_occ_w-1:0] w_occ;
    resp_t              w_head;
    logic               w_head_valid;

    assign w_ld_in_range = {1'b0, ld_addr}  < c_depth_lim;
    assign w_rd_in_range = {1'b0, req_addr} < c_depth_lim;
    assign w_ld_idx      = ld_addr[c_idx_w-1:0];
    assign w_rd_idx      = req_addr[c_idx_w-1:0];
    assign w_rd_word     = r_mem[w_rd_idx];

`ifdef INSTR_PARITY_EN
    assign w_ld_word = {even_parity(c_parity_max_w'(ld_data)), ld_data};
    assign w_rd_err  = !w_rd_in_range ||
                       (even_parity(c_parity_max_w'(w_rd_word[DATA_W-1:0])) != w_rd_word[DATA_W]);
`else
    assign w_ld_word = ld_data;
    assign w_rd_err  = !w_rd_in_range;
`endif

    // Credit counts the word in the read stage so the queue can never overflow.
    assign w_occ     = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_s1_valid};
    assign req_ready = !rst && !flush && (w_occ < c_credit);
    assign w_accept  = req_valid && req_ready;

    // Array is not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (ld_en && w_ld_in_range) begin
            r_mem[w_ld_idx] <= w_ld_word;
        end
    end

    // Fetch samples the array before a same-edge load lands, returning the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1.data <= w_rd_in_range ? w_rd_word[DATA_W-1:0] : NOP_WORD;
                r_s1.addr <= req_addr;
                r_s1.err  <= w_rd_err;
            end
        end
    end

    imem_resp_fifo #(
        .T     (resp_t),
        .DEPTH (RESP_DEPTH),
        .CNT_W (c_cnt_w)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (r_s1_valid),
        .din   (r_s1),
        .pop   (resp_ready),
        .dout  (w_head),
        .valid (w_head_valid),
        .count (w_count)
    );

    assign resp_valid = w_head_valid;
    assign resp_data  = w_head_valid ? w_head.data : '0;
    assign resp_addr  = w_head_valid ? w_head.addr : '0;
    assign resp_err   = w_head_valid ? w_head.err  : 1'b0;

endmodule
`default_nettype wire
